// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the SCCB target.
//   sccb_state_t    - decoder states
//   SCCB_PHASE_BITS - bits per phase (8 data bits + ACK/don't-care bit)
//   SCCB_BYTE_BITS  - data bits per phase
package sccb_pkg;

  localparam int SCCB_PHASE_BITS = 9;
  localparam int SCCB_BYTE_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ID     = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    RD     = 3'd4,
    IGNORE = 3'd5
  } sccb_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: oversamples the SCCB lines on clk.
// Each line goes through a 2-FF synchronizer plus one delay flop; the
// synchronized/delayed pair yields single-clk edge strobes.
// Ports:
//   clk, rst   - system clock, async active-high reset
//   sioc, siod - raw bus lines
//   sioc_rise  - synchronized sioc rising edge strobe
//   sioc_fall  - synchronized sioc falling edge strobe
//   start      - siod fell while sioc high
//   stop       - siod rose while sioc high
//   siod_s     - synchronized siod level
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic sioc,
  input  logic siod,
  output logic sioc_rise,
  output logic sioc_fall,
  output logic start,
  output logic stop,
  output logic siod_s
);

  // [0] metastability flop, [1] synchronized level, [2] delayed level
  logic [2:0] sioc_p;
  logic [2:0] siod_p;

  // Reset to the idle bus level (both lines high) so leaving reset on an
  // idle bus creates no spurious edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sioc_p <= 3'b111;
      siod_p <= 3'b111;
    end else begin
      sioc_p <= {sioc_p[1:0], sioc};
      siod_p <= {siod_p[1:0], siod};
    end
  end

  assign siod_s    = siod_p[1];
  assign sioc_rise =  sioc_p[1] & ~sioc_p[2];
  assign sioc_fall = ~sioc_p[1] &  sioc_p[2];
  // sioc must be stably high across the data edge for START/STOP.
  assign start = sioc_p[1] & sioc_p[2] & ~siod_p[1] &  siod_p[2];
  assign stop  = sioc_p[1] & sioc_p[2] &  siod_p[1] & ~siod_p[2];

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB target (slave) that decodes 3-phase write and 2-phase
// read cycles and presents them to an external register bank.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   sioc      - SCCB clock from the master (oversampled)
//   siod      - SCCB data, target drives only 0 or Z
//   busy      - high from START to STOP
//   wr_valid  - one-clk pulse per received data byte
//   wr_addr   - register address qualified by wr_valid
//   wr_data   - data byte qualified by wr_valid
//   rd_addr   - current sub-address into the bank
//   rd_data   - bank read data (combinational from rd_addr)
//   state_dbg - current decoder state
//
// Bank handshake: wr_valid is a single-clk strobe with no back-pressure;
// wr_addr/wr_data are valid only in that clk and the bank must accept the
// write unconditionally. rd_data must follow rd_addr combinationally; it is
// sampled once per read byte, on the sioc fall that ends the ID ACK bit.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] SID    = 8'h42,
  parameter int          ACK_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  inout  wire        siod,
  output logic       busy,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] LAST_BIT = 4'(SCCB_PHASE_BITS - 1);
  localparam logic [3:0] BYTE_END = 4'(SCCB_BYTE_BITS - 1);

  logic sioc_rise, sioc_fall, start, stop, siod_s;

  sccb_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sioc      (sioc),
    .siod      (siod),
    .sioc_rise (sioc_rise),
    .sioc_fall (sioc_fall),
    .start     (start),
    .stop      (stop),
    .siod_s    (siod_s)
  );

  sccb_state_t state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  rd_sh, rd_sh_n;
  logic        drive_low, drive_low_n;
  logic        busy_n, wr_valid_n;
  logic [7:0]  wr_addr_n, wr_data_n, rd_addr_n;
  logic [7:0]  byte_in;

  assign byte_in = {shreg[6:0], siod_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      rd_sh     <= '0;
      drive_low <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rd_sh     <= rd_sh_n;
      drive_low <= drive_low_n;
      busy      <= busy_n;
      wr_valid  <= wr_valid_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      rd_addr   <= rd_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    rd_sh_n     = rd_sh;
    drive_low_n = drive_low;
    busy_n      = busy;
    wr_valid_n  = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    rd_addr_n   = rd_addr;

    // START/STOP take priority over any bit strobe in the same clk; a
    // partially shifted byte is simply abandoned.
    if (start) begin
      state_n     = ID;
      bit_cnt_n   = '0;
      busy_n      = 1'b1;
      drive_low_n = 1'b0;
    end else if (stop) begin
      state_n     = IDLE;
      bit_cnt_n   = '0;
      busy_n      = 1'b0;
      drive_low_n = 1'b0;
    end else begin
      if (sioc_rise) begin
        if (state == ID || state == ADDR || state == DATA || state == RD) begin
          if (bit_cnt == LAST_BIT) begin
            // ACK/NA bit: phase complete, move on.
            bit_cnt_n = '0;
            case (state)
              ID:      state_n = shreg[0] ? RD : ADDR;
              ADDR:    state_n = DATA;
              DATA:    rd_addr_n = rd_addr + 8'd1;
              RD:      state_n = IGNORE;
              default: state_n = state;
            endcase
          end else begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == BYTE_END) begin
              case (state)
                ID: begin
                  // A foreign ID is dropped before its ACK bit, so the
                  // line is never touched for it.
                  if (byte_in[7:1] != SID[7:1]) state_n = IGNORE;
                end
                ADDR: rd_addr_n = byte_in;
                DATA: begin
                  wr_valid_n = 1'b1;
                  wr_addr_n  = rd_addr;
                  wr_data_n  = byte_in;
                end
                default: ;
              endcase
            end
          end
        end
      end

      // siod only moves after a sioc fall, so it is stable while sioc is high.
      if (sioc_fall) begin
        drive_low_n = 1'b0;
        case (state)
          ID, ADDR, DATA: begin
            if (ACK_EN != 0 && bit_cnt == LAST_BIT) drive_low_n = 1'b1;
          end
          RD: begin
            if (bit_cnt == 4'd0) begin
              // Fall ending the ID ACK: sample the bank once, send bit 7.
              rd_sh_n     = {rd_data[6:0], 1'b1};
              drive_low_n = ~rd_data[7];
            end else if (bit_cnt < LAST_BIT) begin
              rd_sh_n     = {rd_sh[6:0], 1'b1};
              drive_low_n = ~rd_sh[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign siod      = drive_low ? 1'b0 : 1'bz;
  assign state_dbg = state;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: drives SCCB cycles as a bit-level master and checks the
// target against a register-bank level reference model.
`timescale 1ns/1ps
module tb_sccb_target;
  import sccb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic       sioc;
  logic       m_low;
  wire        siod;
  logic       busy, wr_valid;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [2:0] state_dbg;

  assign siod = m_low ? 1'b0 : 1'bz;
  pullup (siod);

  logic [7:0] bank [256];
  assign rd_data = bank[rd_addr];

  sccb_target dut (
    .clk       (clk),
    .rst       (rst),
    .sioc      (sioc),
    .siod      (siod),
    .busy      (busy),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int hp = 8;
  int drv_cnt = 0;
  logic [7:0]  ptr = 8'h00;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  // ---------------- observers ----------------
  always @(negedge clk) begin
    if (wr_valid) got_q.push_back({wr_addr, wr_data});
    if (siod === 1'b0 && !m_low) drv_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic void model_addr(input logic [7:0] a);
    ptr = a;
  endfunction

  function automatic void model_data(input logic [7:0] d);
    exp_q.push_back({ptr, d});
    ptr = ptr + 8'd1;
  endfunction

  // ---------------- master driver ----------------
  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    wclk(2); m_low = 1'b0;
    wclk(hp); sioc = 1'b1;
    wclk(hp); m_low = 1'b1;
    wclk(hp); sioc = 1'b0;
  endtask

  task automatic m_stop();
    wclk(2); m_low = 1'b1;
    wclk(hp); sioc = 1'b1;
    wclk(hp); m_low = 1'b0;
    wclk(hp);
  endtask

  // One bit: data set while sioc low, level sampled mid-high.
  task automatic m_bit(input logic b, output logic r);
    wclk(2); m_low = ~b;
    wclk(hp - 2); sioc = 1'b1;
    wclk(hp / 2); r = (siod === 1'b0) ? 1'b0 : 1'b1;
    wclk(hp - hp / 2); sioc = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic m_rbyte(output logic [7:0] d, output logic ninth);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(1'b1, ninth);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; sioc = 1'b1; m_low = 1'b0;
    wclk(5);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL reset_rd_addr got=%h exp=00", rd_addr); end
    checks++; if (siod !== 1'b1) begin failures++; $display("FAIL reset_siod got=%b exp=1(Z)", siod); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE); end
    rst = 1'b0;
    wclk(5);
  endtask

  task automatic test_write_basic();
    logic a;
    int n;
    hp = 125;
    m_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy_after_start got=%b exp=1", busy); end
    m_byte(8'h42, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_ack_id got=%b exp=1", a); end
    m_byte(8'h12, a); model_addr(8'h12);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_ack_addr got=%b exp=1", a); end
    m_byte(8'h80, a); model_data(8'h80);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_ack_data got=%b exp=1", a); end
    // STOP, counting clks from the siod rise until busy drops
    wclk(2); m_low = 1'b1;
    wclk(hp); sioc = 1'b1;
    wclk(hp); m_low = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (!busy) begin n = i; break; end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL wr_busy_fall_clks got=%0d exp=3", n); end
    wclk(hp);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL wr_write got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL wr_rd_addr got=%h exp=%h", rd_addr, ptr); end
    hp = 8;
  endtask

  task automatic test_ignore();
    logic a;
    int drv0;
    drv0 = drv_cnt;
    m_start();
    m_byte(8'h60, a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL ign_ack got=%b exp=0", a); end
    m_byte(8'($urandom), a);
    m_byte(8'($urandom), a);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
    m_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy_stop got=%b exp=0", busy); end
    checks++; if (drv_cnt != drv0) begin failures++; $display("FAIL ign_drive got=%0d exp=%0d", drv_cnt - drv0, 0); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ign_writes got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_read();
    logic a, nine;
    logic [7:0] d, e;
    bank[8'h0A] = 8'hA5;
    m_start(); m_byte(8'h42, a); m_byte(8'h0A, a); model_addr(8'h0A); m_stop();
    m_start(); m_byte(8'h43, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_ack_id got=%b exp=1", a); end
    checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL rd_addr got=%h exp=%h", rd_addr, ptr); end
    e = bank[ptr];
    m_rbyte(d, nine);
    checks++; if (d !== e) begin failures++; $display("FAIL rd_data got=%h exp=%h", d, e); end
    checks++; if (nine !== 1'b1) begin failures++; $display("FAIL rd_ninth got=%b exp=1", nine); end
    m_stop();
    checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL rd_addr_after got=%h exp=%h", rd_addr, ptr); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rd_writes got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_autoinc();
    logic a;
    m_start(); m_byte(8'h42, a);
    m_byte(8'hFF, a); model_addr(8'hFF);
    m_byte(8'h11, a); model_data(8'h11);
    m_byte(8'h22, a); model_data(8'h22);
    m_stop();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL inc_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL inc_write got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL inc_rd_addr got=%h exp=%h", rd_addr, ptr); end
  endtask

  task automatic test_partial();
    logic a, r;
    logic [7:0] d;
    m_start(); m_byte(8'h42, a);
    m_byte(8'h30, a); model_addr(8'h30);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), r);
    m_stop();
    d = 8'($urandom);
    m_start(); m_byte(8'h42, a);
    m_byte(8'h05, a); model_addr(8'h05);
    m_byte(d, a); model_data(d);
    m_stop();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL part_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL part_write got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_restart();
    logic a, r;
    logic [7:0] d;
    d = 8'($urandom);
    m_start(); m_byte(8'h42, a);
    for (int i = 0; i < 4; i++) m_bit(1'($urandom), r);
    m_start();
    m_byte(8'h42, a);
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL rs_ack_id got=%b exp=1", a); end
    m_byte(8'h07, a); model_addr(8'h07);
    m_byte(d, a); model_data(d);
    m_stop();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rs_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rs_write got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_rst_mid();
    logic a, r;
    logic [7:0] d;
    d = 8'($urandom);
    m_start(); m_byte(8'h42, a);
    m_byte(8'h50, a); model_addr(8'h50);
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    model_data(d);
    // enter the ACK bit and hold sioc high while the target acks
    wclk(2); m_low = 1'b0;
    wclk(hp - 2); sioc = 1'b1;
    wclk(2);
    checks++; if (siod !== 1'b0) begin failures++; $display("FAIL rst_pre_ack got=%b exp=0", siod); end
    rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
    checks++; if (rd_addr !== 8'h00) begin failures++; $display("FAIL rst_rd_addr got=%h exp=00", rd_addr); end
    checks++; if (siod !== 1'b1) begin failures++; $display("FAIL rst_siod got=%b exp=1(Z)", siod); end
    checks++; if (state_dbg !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, IDLE); end
    wclk(3);
    rst = 1'b0;
    ptr = 8'h00;
    wclk(hp);
    d = 8'($urandom);
    m_start(); m_byte(8'h42, a);
    m_byte(8'h3C, a); model_addr(8'h3C);
    m_byte(d, a); model_data(d);
    m_stop();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [15:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rst_write got=%h exp=%h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic a, nine;
    logic [7:0] id, ad, d, e;
    int kind, nb, drv0;
    for (int t = 0; t < 12; t++) begin
      hp = int'($urandom_range(6, 12));
      kind = int'($urandom_range(0, 3));
      drv0 = drv_cnt;
      m_start();
      if (kind <= 1) begin
        ad = 8'($urandom);
        nb = int'($urandom_range(1, 3));
        m_byte(8'h42, a);
        m_byte(ad, a); model_addr(ad);
        for (int k = 0; k < nb; k++) begin
          d = 8'($urandom);
          m_byte(d, a); model_data(d);
          checks++; if (a !== 1'b1) begin failures++; $display("FAIL rnd_ack t=%0d got=%b exp=1", t, a); end
        end
      end else if (kind == 2) begin
        m_byte(8'h43, a);
        e = bank[ptr];
        m_rbyte(d, nine);
        checks++; if (d !== e) begin failures++; $display("FAIL rnd_rd_data t=%0d got=%h exp=%h", t, d, e); end
        checks++; if (nine !== 1'b1) begin failures++; $display("FAIL rnd_rd_ninth t=%0d got=%b exp=1", t, nine); end
      end else begin
        id = 8'($urandom);
        while (id[7:1] == 7'h21) id = 8'($urandom);
        m_byte(id, a);
        m_byte(8'($urandom), a);
        checks++; if (drv_cnt != drv0) begin failures++; $display("FAIL rnd_ign_drive t=%0d got=%0d exp=0", t, drv_cnt - drv0); end
      end
      m_stop();
      checks++; if (rd_addr !== ptr) begin failures++; $display("FAIL rnd_rd_addr t=%0d got=%h exp=%h", t, rd_addr, ptr); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_count t=%0d got=%0d exp=%0d", t, got_q.size(), exp_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        logic [15:0] g, x;
        g = got_q.pop_front(); x = exp_q.pop_front();
        checks++; if (g !== x) begin failures++; $display("FAIL rnd_write t=%0d got=%h exp=%h", t, g, x); end
      end
      got_q.delete(); exp_q.delete();
    end
    hp = 8;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    test_reset();
    test_write_basic();
    test_ignore();
    test_read();
    test_autoinc();
    test_partial();
    test_restart();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
